// File: rtl/mips32_link_pkg.sv
// Shared definitions for the MIPS32 host link: command bytes, FSM states, word geometry.
package mips32_link_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned WORD_W     = WORD_BYTES * BYTE_W;
    localparam int unsigned REG_AW     = 5;

    localparam logic [BYTE_W-1:0] CMD_LOAD = 8'h01;
    localparam logic [BYTE_W-1:0] CMD_RUN  = 8'h02;
    localparam logic [BYTE_W-1:0] CMD_DUMP = 8'h03;

    typedef enum logic [3:0] {
        IDLE,
        LD_AH,
        LD_AL,
        LD_CNT,
        LD_DATA,
        WR,
        RUN,
        DM_CNT,
        DM_RD,
        DM_TX
    } state_t;

    // States in which the link accepts a host byte.
    function automatic logic state_ready(state_t s);
        logic r;
        r = 1'b0;
        case (s)
            IDLE, LD_AH, LD_AL, LD_CNT, LD_DATA, DM_CNT: r = 1'b1;
            default:                                     r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mips32_host_link_if.sv
// Host byte channel, memory write port, register read port and run control.
interface mips32_host_link_if
    import mips32_link_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
);
    logic [BYTE_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [BYTE_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [WORD_W-1:0] mem_wr_data;
    logic [REG_AW-1:0] reg_rd_addr;
    logic [WORD_W-1:0] reg_rd_data;
    logic              cpu_hold;
    logic              pc_clear;
    logic              err;

    // Link side.
    modport master (
        input  in_data, in_valid, out_ready, reg_rd_data,
        output in_ready, out_data, out_valid, mem_wr_en, mem_wr_addr, mem_wr_data,
        output reg_rd_addr, cpu_hold, pc_clear, err
    );

    // Host / core side.
    modport slave (
        output in_data, in_valid, out_ready, reg_rd_data,
        input  in_ready, out_data, out_valid, mem_wr_en, mem_wr_addr, mem_wr_data,
        input  reg_rd_addr, cpu_hold, pc_clear, err
    );
endinterface

// File: rtl/mips32_word_shifter.sv
// 32-bit shift register with byte counter: assembles LOAD words and serializes DUMP words.
module mips32_word_shifter
    import mips32_link_pkg::*;
(
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              load,
    input  logic              shift_in,
    input  logic              shift_out,
    input  logic [WORD_W-1:0] load_word,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word,
    output logic              done_c
);
    localparam int unsigned CNT_W = $clog2(WORD_BYTES);

    logic [CNT_W-1:0] cnt;

    // High when the current shift brings the byte count to four (counter wraps to zero).
    assign done_c = (cnt == CNT_W'(WORD_BYTES - 1));

    // Parallel load, or shift one byte in at the bottom / out at the top, MSB first.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            word <= '0;
            cnt  <= '0;
        end else if (load) begin
            word <= load_word;
            cnt  <= '0;
        end else if (shift_in || shift_out) begin
            word <= {word[WORD_W-BYTE_W-1:0], (shift_in ? byte_in : BYTE_W'(0))};
            cnt  <= cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/mips32_host_link.sv
// Host-side loader/dumper for the MIPS32 core: byte commands LOAD, RUN and DUMP.
module mips32_host_link
    import mips32_link_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned REG_N  = 32
)(
    input  logic               clk1,
    input  logic               rst_n,
    mips32_host_link_if.master bus
);
    localparam logic [BYTE_W-1:0] REG_MAX = BYTE_W'(REG_N);

    state_t            state;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              mem_wr_en_q;
    logic [ADDR_W-1:0] mem_wr_addr_q;
    logic [REG_AW-1:0] reg_rd_addr_q;
    logic              cpu_hold_q;
    logic              pc_clear_q;
    logic              err_q;
    logic [BYTE_W-1:0] addr_hi_q;
    logic [BYTE_W-1:0] words_q;
    logic [BYTE_W-1:0] regs_q;

    logic              in_fire_c;
    logic              out_fire_c;
    logic              sh_load_c;
    logic              sh_in_c;
    logic              sh_out_c;
    logic              sh_done_c;
    logic [WORD_W-1:0] sh_word;

    assign in_fire_c  = bus.in_valid && in_ready_q;
    assign out_fire_c = out_valid_q && bus.out_ready;

    // Realign the byte counter on a new LOAD; capture register data in DM_RD.
    assign sh_load_c = (state == DM_RD) ||
                       ((state == IDLE) && in_fire_c && (bus.in_data == CMD_LOAD));
    assign sh_in_c   = (state == LD_DATA) && in_fire_c;
    assign sh_out_c  = (state == DM_TX) && out_fire_c;

    mips32_word_shifter u_shifter (
        .clk1      (clk1),
        .rst_n     (rst_n),
        .load      (sh_load_c),
        .shift_in  (sh_in_c),
        .shift_out (sh_out_c),
        .load_word (bus.reg_rd_data),
        .byte_in   (bus.in_data),
        .word      (sh_word),
        .done_c    (sh_done_c)
    );

    // Command FSM with registered outputs; in_ready tracks the state being entered.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            in_ready_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            mem_wr_en_q   <= 1'b0;
            mem_wr_addr_q <= '0;
            reg_rd_addr_q <= '0;
            cpu_hold_q    <= 1'b1;
            pc_clear_q    <= 1'b0;
            err_q         <= 1'b0;
            addr_hi_q     <= '0;
            words_q       <= '0;
            regs_q        <= '0;
        end else begin
            in_ready_q  <= state_ready(state);
            mem_wr_en_q <= 1'b0;
            pc_clear_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_fire_c) begin
                        case (bus.in_data)
                            CMD_LOAD: begin
                                state      <= LD_AH;
                                cpu_hold_q <= 1'b1;
                            end
                            CMD_RUN: begin
                                state      <= RUN;
                                in_ready_q <= 1'b0;
                                cpu_hold_q <= 1'b0;
                                pc_clear_q <= 1'b1;
                            end
                            CMD_DUMP: state <= DM_CNT;
                            default:  err_q <= 1'b1;
                        endcase
                    end
                end
                LD_AH: begin
                    if (in_fire_c) begin
                        addr_hi_q <= bus.in_data;
                        state     <= LD_AL;
                    end
                end
                LD_AL: begin
                    if (in_fire_c) begin
                        mem_wr_addr_q <= ADDR_W'({addr_hi_q, bus.in_data});
                        state         <= LD_CNT;
                    end
                end
                LD_CNT: begin
                    if (in_fire_c) begin
                        if (bus.in_data == '0) begin
                            state <= IDLE;
                        end else begin
                            words_q <= bus.in_data;
                            state   <= LD_DATA;
                        end
                    end
                end
                LD_DATA: begin
                    if (in_fire_c && sh_done_c) begin
                        state       <= WR;
                        in_ready_q  <= 1'b0;
                        mem_wr_en_q <= 1'b1;
                    end
                end
                WR: begin
                    mem_wr_addr_q <= mem_wr_addr_q + ADDR_W'(1);
                    in_ready_q    <= 1'b1;
                    if (words_q == BYTE_W'(1)) begin
                        state <= IDLE;
                    end else begin
                        words_q <= words_q - BYTE_W'(1);
                        state   <= LD_DATA;
                    end
                end
                RUN: begin
                    state      <= IDLE;
                    in_ready_q <= 1'b1;
                end
                DM_CNT: begin
                    if (in_fire_c) begin
                        if (bus.in_data == '0) begin
                            state <= IDLE;
                        end else begin
                            regs_q        <= (bus.in_data > REG_MAX) ? REG_MAX : bus.in_data;
                            reg_rd_addr_q <= '0;
                            in_ready_q    <= 1'b0;
                            state         <= DM_RD;
                        end
                    end
                end
                DM_RD: begin
                    out_valid_q <= 1'b1;
                    state       <= DM_TX;
                end
                DM_TX: begin
                    if (out_fire_c && sh_done_c) begin
                        out_valid_q <= 1'b0;
                        if ((BYTE_W'(reg_rd_addr_q) + BYTE_W'(1)) == regs_q) begin
                            state      <= IDLE;
                            in_ready_q <= 1'b1;
                        end else begin
                            reg_rd_addr_q <= reg_rd_addr_q + REG_AW'(1);
                            state         <= DM_RD;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = sh_word[WORD_W-1 -: BYTE_W];
    assign bus.mem_wr_en   = mem_wr_en_q;
    assign bus.mem_wr_addr = mem_wr_addr_q;
    assign bus.mem_wr_data = sh_word;
    assign bus.reg_rd_addr = reg_rd_addr_q;
    assign bus.cpu_hold    = cpu_hold_q;
    assign bus.pc_clear    = pc_clear_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_mips32_host_link.sv
// Self-checking bench for mips32_host_link: vector tables plus write/byte scoreboards.
module tb_mips32_host_link;
    import mips32_link_pkg::*;

    localparam int unsigned ADDR_W = 10;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    typedef struct {
        logic [31:0]       word;
        logic [ADDR_W-1:0] exp_addr;
    } ld_vec_t;

    typedef struct {
        logic [7:0] m;
        int         exp_regs;
        bit         rnd;
    } dm_vec_t;

    logic clk1;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;
    int   wr_count;
    int   pc_count;
    int   last_wr_cyc;
    int   last_out_cyc;
    bit   rnd_mode;
    bit   held_valid;
    logic [7:0] held_byte;

    wr_t        exp_wr[$];
    logic [7:0] exp_out[$];

    mips32_host_link_if #(.ADDR_W(ADDR_W)) bus ();

    mips32_host_link #(.ADDR_W(ADDR_W), .REG_N(32)) dut (
        .clk1  (clk1),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Register file model: Reg[k] = k.
    assign bus.reg_rd_data = 32'(bus.reg_rd_addr);

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    always @(posedge clk1) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    // Output-side scoreboard and out_ready driver, on the falling edge.
    initial begin
        wr_t e;
        logic [7:0] b;
        bus.out_ready = 1'b1;
        held_valid    = 1'b0;
        forever begin
            @(negedge clk1);
            bus.out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.pc_clear) pc_count++;
            if (bus.mem_wr_en) begin
                wr_count++;
                last_wr_cyc = cyc;
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr_unexpected got addr %0h data %0h want no write",
                             bus.mem_wr_addr, bus.mem_wr_data);
                end else begin
                    e = exp_wr.pop_front();
                    chk("wr_addr", 64'(bus.mem_wr_addr), 64'(e.addr));
                    chk("wr_data", 64'(bus.mem_wr_data), 64'(e.data));
                    chk("wr_hold", 64'(bus.cpu_hold), 64'(1));
                end
            end
            if (bus.out_valid) begin
                if (held_valid) chk("out_stable", 64'(bus.out_data), 64'(held_byte));
                if (bus.out_ready) begin
                    last_out_cyc = cyc;
                    held_valid   = 1'b0;
                    if (exp_out.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL out_unexpected got %0h want no byte", bus.out_data);
                    end else begin
                        b = exp_out.pop_front();
                        chk("out_byte", 64'(bus.out_data), 64'(b));
                    end
                end else begin
                    held_valid = 1'b1;
                    held_byte  = bus.out_data;
                end
            end else begin
                if (held_valid && rst_n) begin
                    checks++;
                    errors++;
                    $display("FAIL out_valid_drop got 0 want 1");
                end
                held_valid = 1'b0;
            end
        end
    end

    // Present one byte from a falling edge; returns on the falling edge after acceptance.
    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && t < 200) begin
            @(negedge clk1);
            t++;
        end
        if (t >= 200) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout got 0 want 1");
        end else begin
            @(negedge clk1);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8]);
    endtask

    // Wait until both scoreboards are empty and the link is idle again.
    task automatic drain(input string name);
        int t;
        t = 0;
        while ((exp_wr.size() != 0 || exp_out.size() != 0) && t < 3000) begin
            @(negedge clk1);
            t++;
        end
        chk(name, 64'(exp_wr.size() + exp_out.size()), 64'(0));
        t = 0;
        while (!bus.in_ready && t < 50) begin
            @(negedge clk1);
            t++;
        end
    endtask

    task automatic push_regs(input int n);
        logic [31:0] v;
        for (int k = 0; k < n; k++) begin
            v = 32'(k);
            for (int i = 0; i < 4; i++) exp_out.push_back(v[31-8*i -: 8]);
        end
    endtask

    initial begin
        ld_vec_t ld_tab[7];
        dm_vec_t dm_tab[7];
        int      t0;
        int      wr_before;

        ld_tab[0] = '{32'h2801000a, 10'd0};
        ld_tab[1] = '{32'h28020014, 10'd1};
        ld_tab[2] = '{32'h28030019, 10'd2};
        ld_tab[3] = '{32'h00222000, 10'd3};
        ld_tab[4] = '{32'h0c373800, 10'd4};
        ld_tab[5] = '{32'h00832800, 10'd5};
        ld_tab[6] = '{32'hfc000000, 10'd6};

        dm_tab[0] = '{8'h06, 6,  1'b0};
        dm_tab[1] = '{8'h06, 6,  1'b1};
        dm_tab[2] = '{8'h00, 0,  1'b0};
        dm_tab[3] = '{8'h40, 32, 1'b0};
        dm_tab[4] = '{8'h21, 32, 1'b1};
        dm_tab[5] = '{8'h01, 1,  1'b0};
        dm_tab[6] = '{8'h20, 32, 1'b0};

        checks       = 0;
        errors       = 0;
        cyc          = 0;
        wr_count     = 0;
        pc_count     = 0;
        last_wr_cyc  = 0;
        last_out_cyc = 0;
        rnd_mode     = 1'b0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        // Reset values.
        repeat (3) @(negedge clk1);
        chk("rst_in_ready",  64'(bus.in_ready),  64'(0));
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_wr_en",     64'(bus.mem_wr_en), 64'(0));
        chk("rst_cpu_hold",  64'(bus.cpu_hold),  64'(1));
        chk("rst_pc_clear",  64'(bus.pc_clear),  64'(0));
        chk("rst_err",       64'(bus.err),       64'(0));
        chk("rst_wr_addr",   64'(bus.mem_wr_addr), 64'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk1);
        chk("idle_in_ready", 64'(bus.in_ready), 64'(1));

        // Program load at 0: 7 words, 5 cycles per word.
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h07);
        t0 = cyc;
        for (int i = 0; i < 7; i++) begin
            exp_wr.push_back('{ld_tab[i].exp_addr, ld_tab[i].word});
            send_word(ld_tab[i].word);
        end
        drain("load_drain");
        chk("load_count",  64'(wr_count), 64'(7));
        chk("load_cycles", 64'(last_wr_cyc - t0), 64'(34));
        chk("load_hold",   64'(bus.cpu_hold), 64'(1));

        // RUN: one-cycle pc_clear, hold released in the same cycle.
        send_byte(8'h02);
        chk("run_pc_clear", 64'(bus.pc_clear), 64'(1));
        chk("run_hold",     64'(bus.cpu_hold), 64'(0));
        chk("run_in_ready", 64'(bus.in_ready), 64'(0));
        @(negedge clk1);
        chk("run_pc_clear_end", 64'(bus.pc_clear), 64'(0));
        chk("run_in_ready_end", 64'(bus.in_ready), 64'(1));
        chk("run_hold_end",     64'(bus.cpu_hold), 64'(0));

        // DUMP table.
        for (int i = 0; i < 7; i++) begin
            rnd_mode = dm_tab[i].rnd;
            push_regs(dm_tab[i].exp_regs);
            send_byte(8'h03);
            send_byte(dm_tab[i].m);
            t0 = cyc;
            drain($sformatf("dump%0d_drain", i));
            if (!dm_tab[i].rnd && dm_tab[i].exp_regs > 0)
                chk($sformatf("dump%0d_cycles", i), 64'(last_out_cyc - t0),
                    64'(5 * dm_tab[i].exp_regs - 1));
            chk($sformatf("dump%0d_idle", i), 64'(bus.in_ready), 64'(1));
        end
        rnd_mode = 1'b0;

        // LOAD while running re-freezes the core; address wraps at 0x3FF.
        send_byte(8'h01);
        chk("reload_hold", 64'(bus.cpu_hold), 64'(1));
        send_byte(8'h03); send_byte(8'hff); send_byte(8'h02);
        exp_wr.push_back('{10'h3ff, 32'hdeadbeef});
        exp_wr.push_back('{10'h000, 32'h12345678});
        send_word(32'hdeadbeef);
        send_word(32'h12345678);
        drain("wrap_drain");
        chk("pc_pulses", 64'(pc_count), 64'(1));

        // Unknown command sets sticky err; a following load still works.
        send_byte(8'h7f);
        chk("err_set",      64'(bus.err),      64'(1));
        chk("err_in_ready", 64'(bus.in_ready), 64'(1));
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h10); send_byte(8'h01);
        exp_wr.push_back('{10'h010, 32'ha5a55a5a});
        send_word(32'ha5a55a5a);
        drain("err_load_drain");
        chk("err_sticky", 64'(bus.err), 64'(1));

        // LOAD with N=0 writes nothing and returns to IDLE.
        wr_before = wr_count;
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h20); send_byte(8'h00);
        repeat (10) @(negedge clk1);
        chk("n0_no_write", 64'(wr_count - wr_before), 64'(0));
        chk("n0_idle",     64'(bus.in_ready), 64'(1));

        // Reset after two data bytes abandons the word.
        wr_before = wr_count;
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h05); send_byte(8'h01);
        send_byte(8'h11); send_byte(8'h22);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wr_en", 64'(bus.mem_wr_en), 64'(0));
        chk("mid_rst_hold",  64'(bus.cpu_hold),  64'(1));
        chk("mid_rst_err",   64'(bus.err),       64'(0));
        repeat (3) @(negedge clk1);
        rst_n = 1'b1;
        repeat (10) @(negedge clk1);
        chk("mid_rst_no_write", 64'(wr_count - wr_before), 64'(0));
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h05); send_byte(8'h01);
        exp_wr.push_back('{10'h005, 32'h55667788});
        send_word(32'h55667788);
        drain("fresh_load_drain");
        chk("fresh_load_count", 64'(wr_count - wr_before), 64'(1));

        repeat (5) @(negedge clk1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
